// File: rtl/dsp_pkg.sv
// Shared DSP slice definitions: default widths, opmode field layout and
// the X/Z operand-select encodings used by the post-adder.
package dsp_pkg;

   localparam int P_W_DEF = 48;
   localparam int M_W_DEF = 36;

   localparam int OPM_X_LSB   = 0;
   localparam int OPM_Z_LSB   = 2;
   localparam int OPM_SUB_BIT = 4;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_C    = 2'b11
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_P    = 2'b01,
      Z_C    = 2'b10,
      Z_RSV  = 2'b11
   } z_sel_e;

endpackage

// File: rtl/post_adder.sv
// Combinational X/Z select, add/subtract, signed-overflow detect and,
// when ACC_SAT_EN is defined, saturation of overflowing results.
module post_adder
   import dsp_pkg::*;
#(
   parameter int P_W = P_W_DEF
) (
   input  logic signed [P_W-1:0] m_val,
   input  logic signed [P_W-1:0] c_val,
   input  logic signed [P_W-1:0] p_fb,
   input  logic        [4:0]     opmode,
   input  logic                  cin,
   output logic signed [P_W-1:0] result,
   output logic                  carry,
   output logic                  ovf
);

   x_sel_e                x_sel;
   z_sel_e                z_sel;
   logic                  sub;
   logic signed [P_W-1:0] x_op;
   logic signed [P_W-1:0] z_op;
   logic signed [P_W+1:0] x_ext;
   logic signed [P_W+1:0] z_ext;
   logic signed [P_W+1:0] cin_ext;
   logic signed [P_W+1:0] full;

`ifdef ACC_SAT_EN
   function automatic logic signed [P_W-1:0] saturate(input logic neg);
      return neg ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
   endfunction
`endif

   assign x_sel = x_sel_e'(opmode[OPM_X_LSB +: 2]);
   assign z_sel = z_sel_e'(opmode[OPM_Z_LSB +: 2]);
   assign sub   = opmode[OPM_SUB_BIT];

   always_comb begin
      x_op = '0;
      case (x_sel)
         X_M:     x_op = m_val;
         X_P:     x_op = p_fb;
         X_C:     x_op = c_val;
         default: x_op = '0;
      endcase
      z_op = '0;
      case (z_sel)
         Z_P:     z_op = p_fb;
         Z_C:     z_op = c_val;
         default: z_op = '0;
      endcase
   end

   // Two guard bits keep the exact signed result of Z +/- (X + cin).
   assign x_ext   = {{2{x_op[P_W-1]}}, x_op};
   assign z_ext   = {{2{z_op[P_W-1]}}, z_op};
   assign cin_ext = {{(P_W+1){1'b0}}, cin};
   assign full    = sub ? (z_ext - (x_ext + cin_ext)) : (z_ext + x_ext + cin_ext);

   // Unsigned bit P_W differs from the signed one by the operand sign bits.
   assign carry = full[P_W] ^ z_op[P_W-1] ^ x_op[P_W-1];
   assign ovf   = ~((&full[P_W+1:P_W-1]) | ~(|full[P_W+1:P_W-1]));

`ifdef ACC_SAT_EN
   assign result = ovf ? saturate(full[P_W+1]) : full[P_W-1:0];
`else
   assign result = full[P_W-1:0];
`endif

endmodule

// File: rtl/mac_post_accumulator.sv
// Two-stage MAC post-accumulator with valid/ready handshakes on both sides.
// Optional saturation of overflowing results via ACC_SAT_EN (in post_adder).
module mac_post_accumulator
   import dsp_pkg::*;
#(
   parameter int P_W = P_W_DEF,
   parameter int M_W = M_W_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic signed [M_W-1:0] m_in,
   input  logic signed [P_W-1:0] c_in,
   input  logic        [4:0]     opmode,
   input  logic                  carry_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  acc_clr,
   output logic signed [P_W-1:0] p_out,
   output logic                  carry_out,
   output logic                  ovf,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic signed [P_W-1:0] m_reg;
   logic signed [P_W-1:0] c_reg;
   logic        [4:0]     opmode_reg;
   logic                  cin_reg;
   logic                  m_valid;
   logic                  accept;
   logic                  advance;
   logic signed [P_W-1:0] sum;
   logic                  sum_carry;
   logic                  sum_ovf;

   assign advance  = m_valid && (!out_valid || out_ready);
   assign in_ready = !acc_clr && (!m_valid || !out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   post_adder #(.P_W(P_W)) u_post_adder (
      .m_val  (m_reg),
      .c_val  (c_reg),
      .p_fb   (p_out),
      .opmode (opmode_reg),
      .cin    (cin_reg),
      .result (sum),
      .carry  (sum_carry),
      .ovf    (sum_ovf)
   );

   // Stage M: operand capture
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_reg      <= '0;
         c_reg      <= '0;
         opmode_reg <= '0;
         cin_reg    <= 1'b0;
         m_valid    <= 1'b0;
      end else if (acc_clr) begin
         m_valid <= 1'b0;
      end else if (accept) begin
         m_reg      <= {{(P_W-M_W){m_in[M_W-1]}}, m_in};
         c_reg      <= c_in;
         opmode_reg <= opmode;
         cin_reg    <= carry_in;
         m_valid    <= 1'b1;
      end else if (advance) begin
         m_valid <= 1'b0;
      end
   end

   // Stage P: result register, held while the consumer stalls
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p_out     <= '0;
         carry_out <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (acc_clr) begin
         p_out     <= '0;
         carry_out <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         p_out     <= sum;
         carry_out <= sum_carry;
         ovf       <= sum_ovf;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/mac_post_accumulator.md
MAC_POST_ACCUMULATOR -- requirements
Module: mac_post_accumulator

Interface
REQ-001 SHALL have parameter P_W, default 48, meaning accumulator/P width.
REQ-002 SHALL have parameter M_W, default 36, meaning signed product width from the 18x18 multiplier.
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port m_in  input  M_W  signed product from the multiplier.
REQ-006 SHALL have port c_in  input  P_W  signed C operand.
REQ-007 SHALL have port opmode  input  5  [1:0] X select, [3:2] Z select, [4] subtract.
REQ-008 SHALL have port carry_in  input  1  adder carry-in.
REQ-009 SHALL have port in_valid / in_ready  input / output  1 each  upstream handshake.
REQ-010 SHALL have port acc_clr  input  1  synchronous accumulator clear.
REQ-011 SHALL have port p_out  output  P_W  registered result.
REQ-012 SHALL have port carry_out  output  1  registered adder carry (bit P_W of unsigned sum).
REQ-013 SHALL have port ovf  output  1  registered signed-overflow/saturation flag.
REQ-014 SHALL have port out_valid / out_ready  output / input  1 each  downstream handshake.

Function
REQ-015 SHALL be a 2-stage pipeline: stage M (m_reg, c_reg, opmode_reg, cin_reg, m_valid), stage P (p_out, carry_out, ovf, out_valid).
REQ-016 SHALL accept a beat when in_valid && in_ready; m_in sign-extended to P_W on capture.
REQ-017 SHALL compute stage P only when m_valid && (!out_valid || out_ready); latency 2 cycles from acceptance to out_valid with no backpressure.
REQ-018 SHALL drive in_ready = !m_valid || (!out_valid || out_ready), combinationally, and 0 during acc_clr.
REQ-019 SHALL decode X: 00 zero, 01 m_reg, 10 p_out (feedback), 11 c_reg.
REQ-020 SHALL decode Z: 00 zero, 01 p_out, 10 c_reg, 11 zero (reserved).
REQ-021 SHALL compute Z + X + cin when opmode[4]=0, Z - (X + cin) when opmode[4]=1, in P_W+1 bits; carry_out = bit P_W.
REQ-022 SHALL use the current p_out register value as feedback regardless of out_valid.
REQ-023 SHALL hold p_out, carry_out, ovf, out_valid stable while out_valid && !out_ready.
REQ-024 SHALL clear out_valid on handshake when no new stage-P result is produced that cycle.
REQ-025 SHALL on acc_clr=1 zero p_out, carry_out, ovf and clear m_valid and out_valid next edge; acc_clr wins over any simultaneous accept or advance (beat dropped).
REQ-026 SHALL set ovf when the signed result exceeds P_W bits (operand signs equal, result sign differs), per result.

Reset
REQ-027 SHALL on RST=1 asynchronously zero m_reg, c_reg, opmode_reg, cin_reg, m_valid, p_out, carry_out, ovf, out_valid.
REQ-028 SHALL drop any in-flight beat on reset mid-operation; in_ready = 1 after release.

Configuration
REQ-029 SHALL, with ACC_SAT_EN defined, clamp overflowing results to 0x7FFF_FFFF_FFFF (positive) or 0x8000_0000_0000 (negative) and assert ovf.
REQ-030 SHALL, without ACC_SAT_EN, wrap modulo 2^P_W, with ovf still reporting overflow; ports identical in both builds.

Structure
REQ-031 SHALL take P_W/M_W defaults, opmode field positions and X/Z select encodings from shared package dsp_pkg.
REQ-032 SHALL place the X/Z mux, adder/subtractor, overflow detect and optional saturation in combinational sub-module post_adder; registers and handshake stay in the top.

Verification
REQ-033 SHALL test accumulate: opmode=00101, m_in=6, then m_in=-2 (out_ready=1) -> p_out=6 then 4, out_valid each 2 cycles after accept.
REQ-034 SHALL test subtract with C: c_in=100, m_in=30, opmode=11001, carry_in=1 -> p_out=69.
REQ-035 SHALL test backpressure: out_ready=0 for 3 cycles with 2 beats sent -> in_ready falls after 2nd beat, p_out held, both results delivered in order once out_ready=1.
REQ-036 SHALL test overflow: p_out=0x7FFF_FFFF_FFFF, opmode=00101, m_in=1 -> ACC_SAT_EN: p_out=0x7FFF_FFFF_FFFF, ovf=1; else p_out=0x8000_0000_0000, ovf=1.
REQ-037 SHALL test clear collision: acc_clr=1 with in_valid=1 and m_valid=1 -> next cycle p_out=0, out_valid=0, m_valid=0, beat not accepted.
REQ-038 SHALL test async reset: RST pulse mid-cycle with both stages valid -> all outputs 0 immediately, in_ready=1 after release.
